// File: rtl/basic_datapath_io.sv
// Parametrised basic-computer datapath: common bus, architectural registers, ALU,
// word-addressed memory and INPR/OUTR handshake ports driven by an external control unit.
module basic_datapath_io #(
  parameter int unsigned                  DATA_WIDTH = 16,
  parameter int unsigned                  ADDR_WIDTH = 12,
  parameter int unsigned                  IO_WIDTH   = 8,
  parameter logic [ADDR_WIDTH-1:0]        PC_RESET   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic [2:0]            bus_select,
  input  logic [2:0]            alu_select,

  input  logic                  ld_AR,
  input  logic                  ld_PC,
  input  logic                  ld_DR,
  input  logic                  ld_AC,
  input  logic                  ld_IR,
  input  logic                  ld_TR,

  input  logic                  clr_AR,
  input  logic                  clr_PC,
  input  logic                  clr_AC,

  input  logic                  inc_AR,
  input  logic                  inc_PC,
  input  logic                  inc_DR,
  input  logic                  inc_AC,

  input  logic                  clr_E,
  input  logic                  comp_E,
  input  logic                  set_IEN,
  input  logic                  clr_IEN,
  input  logic                  set_R,
  input  logic                  clr_R,
  input  logic                  clr_FGI,
  input  logic                  ld_OUTR,

  input  logic                  write_en,

  input  logic                  in_valid,
  input  logic [IO_WIDTH-1:0]   in_data,
  output logic                  in_ready,

  output logic                  out_valid,
  output logic [IO_WIDTH-1:0]   out_data,
  input  logic                  out_ready,

  output logic [ADDR_WIDTH-1:0] AR,
  output logic [ADDR_WIDTH-1:0] PC,
  output logic [DATA_WIDTH-1:0] DR,
  output logic [DATA_WIDTH-1:0] AC,
  output logic [DATA_WIDTH-1:0] IR,
  output logic [DATA_WIDTH-1:0] TR,

  output logic                  E,
  output logic                  IEN,
  output logic                  R,
  output logic                  FGI,
  output logic                  FGO,

  output logic [3:0]            flags,
  output logic                  irq_pending
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam logic [DATA_WIDTH-1:0] IO_MASK = DATA_WIDTH'({IO_WIDTH{1'b1}});

  typedef enum logic [2:0] {
    BUS_ZERO = 3'd0,
    BUS_AR   = 3'd1,
    BUS_PC   = 3'd2,
    BUS_DR   = 3'd3,
    BUS_AC   = 3'd4,
    BUS_IR   = 3'd5,
    BUS_TR   = 3'd6,
    BUS_MEM  = 3'd7
  } bus_sel_e;

  typedef enum logic [2:0] {
    ALU_AND  = 3'd0,
    ALU_ADD  = 3'd1,
    ALU_LDR  = 3'd2,
    ALU_CMA  = 3'd3,
    ALU_INP  = 3'd4,
    ALU_CIR  = 3'd5,
    ALU_CIL  = 3'd6,
    ALU_PASS = 3'd7
  } alu_op_e;

  logic [ADDR_WIDTH-1:0] ar_q, ar_d, pc_q, pc_d;
  logic [DATA_WIDTH-1:0] dr_q, dr_d, ac_q, ac_d, ir_q, ir_d, tr_q, tr_d;
  logic [IO_WIDTH-1:0]   inpr_q, inpr_d, outr_q, outr_d;
  logic                  e_q, e_d, ien_q, ien_d, r_q, r_d;
  logic                  fgi_q, fgi_d, fgo_q, fgo_d;
  logic [3:0]            flags_q, flags_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] bus;

  logic [DATA_WIDTH:0]   add_sum;
  logic [DATA_WIDTH-1:0] alu_res;
  logic                  alu_co, alu_ovf, alu_e, alu_e_we;

  always_comb begin
    unique case (bus_sel_e'(bus_select))
      BUS_ZERO: bus = '0;
      BUS_AR:   bus = DATA_WIDTH'(ar_q);
      BUS_PC:   bus = DATA_WIDTH'(pc_q);
      BUS_DR:   bus = dr_q;
      BUS_AC:   bus = ac_q;
      BUS_IR:   bus = ir_q;
      BUS_TR:   bus = tr_q;
      BUS_MEM:  bus = mem_q[ar_q];
      default:  bus = '0;
    endcase
  end

  assign add_sum = {1'b0, ac_q} + {1'b0, dr_q};

  // E is rotated through AC as a (DATA_WIDTH+1)-bit ring by CIR/CIL.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    alu_res  = ac_q;
    alu_co   = 1'b0;
    alu_ovf  = 1'b0;
    alu_e    = e_q;
    alu_e_we = 1'b0;
    unique case (alu_op_e'(alu_select))
      ALU_AND:  alu_res = ac_q & dr_q;
      ALU_ADD: begin
        alu_res  = add_sum[DATA_WIDTH-1:0];
        alu_co   = add_sum[DATA_WIDTH];
        alu_ovf  = (ac_q[DATA_WIDTH-1] == dr_q[DATA_WIDTH-1]) &&
                   (add_sum[DATA_WIDTH-1] != ac_q[DATA_WIDTH-1]);
        alu_e    = add_sum[DATA_WIDTH];
        alu_e_we = 1'b1;
      end
      ALU_LDR:  alu_res = dr_q;
      ALU_CMA:  alu_res = ~ac_q;
      ALU_INP:  alu_res = (ac_q & ~IO_MASK) | DATA_WIDTH'(inpr_q);
      ALU_CIR: begin
        alu_res  = {e_q, ac_q[DATA_WIDTH-1:1]};
        alu_e    = ac_q[0];
        alu_e_we = 1'b1;
      end
      ALU_CIL: begin
        alu_res  = {ac_q[DATA_WIDTH-2:0], e_q};
        alu_e    = ac_q[DATA_WIDTH-1];
        alu_e_we = 1'b1;
      end
      ALU_PASS: alu_res = ac_q;
      default:  alu_res = ac_q;
    endcase
  end

  always_comb begin
    ar_d    = ar_q;
    pc_d    = pc_q;
    dr_d    = dr_q;
    ac_d    = ac_q;
    ir_d    = ir_q;
    tr_d    = tr_q;
    e_d     = e_q;
    ien_d   = ien_q;
    r_d     = r_q;
    fgi_d   = fgi_q;
    fgo_d   = fgo_q;
    inpr_d  = inpr_q;
    outr_d  = outr_q;
    flags_d = flags_q;

    if (clr_AR)      ar_d = '0;
    else if (ld_AR)  ar_d = bus[ADDR_WIDTH-1:0];
    else if (inc_AR) ar_d = ar_q + ADDR_WIDTH'(1);

    if (clr_PC)      pc_d = PC_RESET;
    else if (ld_PC)  pc_d = bus[ADDR_WIDTH-1:0];
    else if (inc_PC) pc_d = pc_q + ADDR_WIDTH'(1);

    if (ld_DR)       dr_d = bus;
    else if (inc_DR) dr_d = dr_q + DATA_WIDTH'(1);

    if (clr_AC)      ac_d = '0;
    else if (ld_AC)  ac_d = alu_res;
    else if (inc_AC) ac_d = ac_q + DATA_WIDTH'(1);

    if (ld_IR) ir_d = bus;
    if (ld_TR) tr_d = bus;

    // Flags and the ALU's E write follow ld_AC alone, even if clr_AC overrides the AC value.
    if (ld_AC) flags_d = {alu_co, alu_ovf, alu_res[DATA_WIDTH-1], alu_res == '0};

    if (clr_E)                    e_d = 1'b0;
    else if (comp_E)              e_d = ~e_q;
    else if (ld_AC && alu_e_we)   e_d = alu_e;

    if (set_IEN)      ien_d = 1'b1;
    else if (clr_IEN) ien_d = 1'b0;

    if (set_R)      r_d = 1'b1;
    else if (clr_R) r_d = 1'b0;

    if (clr_FGI) begin
      fgi_d = 1'b0;
    end else if (in_valid && !fgi_q) begin
      fgi_d  = 1'b1;
      inpr_d = in_data;
    end

    if (ld_OUTR) begin
      outr_d = ac_q[IO_WIDTH-1:0];
      fgo_d  = 1'b0;
    end else if (!fgo_q && out_ready) begin
      fgo_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar_q    <= '0;
      pc_q    <= PC_RESET;
      dr_q    <= '0;
      ac_q    <= '0;
      ir_q    <= '0;
      tr_q    <= '0;
      e_q     <= 1'b0;
      ien_q   <= 1'b0;
      r_q     <= 1'b0;
      fgi_q   <= 1'b0;
      fgo_q   <= 1'b1;
      inpr_q  <= '0;
      outr_q  <= '0;
      flags_q <= '0;
    end else begin
      ar_q    <= ar_d;
      pc_q    <= pc_d;
      dr_q    <= dr_d;
      ac_q    <= ac_d;
      ir_q    <= ir_d;
      tr_q    <= tr_d;
      e_q     <= e_d;
      ien_q   <= ien_d;
      r_q     <= r_d;
      fgi_q   <= fgi_d;
      fgo_q   <= fgo_d;
      inpr_q  <= inpr_d;
      outr_q  <= outr_d;
      flags_q <= flags_d;
    end
  end

  // NOTE: the memory array has no reset; clearing it would force flops instead of a RAM macro.
  always_ff @(posedge clk) begin
    if (write_en) mem_q[ar_q] <= bus;
  end

  assign AR          = ar_q;
  assign PC          = pc_q;
  assign DR          = dr_q;
  assign AC          = ac_q;
  assign IR          = ir_q;
  assign TR          = tr_q;
  assign E           = e_q;
  assign IEN         = ien_q;
  assign R           = r_q;
  assign FGI         = fgi_q;
  assign FGO         = fgo_q;
  assign flags       = flags_q;
  assign out_data    = outr_q;
  assign in_ready    = ~fgi_q;
  assign out_valid   = ~fgo_q;
  assign irq_pending = ien_q & (fgi_q | fgo_q);

endmodule

// File: tb/tb_basic_datapath_io.sv
// Self-checking bench for basic_datapath_io: directed scenarios with literal expectations,
// then randomized control streams checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_basic_datapath_io;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  bus_select, alu_select;
  logic        ld_AR, ld_PC, ld_DR, ld_AC, ld_IR, ld_TR;
  logic        clr_AR, clr_PC, clr_AC;
  logic        inc_AR, inc_PC, inc_DR, inc_AC;
  logic        clr_E, comp_E, set_IEN, clr_IEN, set_R, clr_R, clr_FGI, ld_OUTR;
  logic        write_en, in_valid, out_ready;
  logic [7:0]  in_data;
  logic        in_ready, out_valid;
  logic [7:0]  out_data;
  logic [11:0] AR, PC;
  logic [15:0] DR, AC, IR, TR;
  logic        E, IEN, R, FGI, FGO;
  logic [3:0]  flags;
  logic        irq_pending;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [11:0] m_ar, m_pc, n_ar, n_pc;
  logic [15:0] m_dr, m_ac, m_ir, m_tr, n_dr, n_ac, n_ir, n_tr;
  logic [7:0]  m_inpr, m_outr, n_inpr, n_outr;
  logic        m_e, m_ien, m_r, m_fgi, m_fgo, n_e, n_ien, n_r, n_fgi, n_fgo;
  logic [3:0]  m_flags, n_flags;
  logic [15:0] m_mem [int];

  basic_datapath_io dut (
    .clk(clk), .rst_n(rst_n),
    .bus_select(bus_select), .alu_select(alu_select),
    .ld_AR(ld_AR), .ld_PC(ld_PC), .ld_DR(ld_DR), .ld_AC(ld_AC), .ld_IR(ld_IR), .ld_TR(ld_TR),
    .clr_AR(clr_AR), .clr_PC(clr_PC), .clr_AC(clr_AC),
    .inc_AR(inc_AR), .inc_PC(inc_PC), .inc_DR(inc_DR), .inc_AC(inc_AC),
    .clr_E(clr_E), .comp_E(comp_E), .set_IEN(set_IEN), .clr_IEN(clr_IEN),
    .set_R(set_R), .clr_R(clr_R), .clr_FGI(clr_FGI), .ld_OUTR(ld_OUTR),
    .write_en(write_en),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .AR(AR), .PC(PC), .DR(DR), .AC(AC), .IR(IR), .TR(TR),
    .E(E), .IEN(IEN), .R(R), .FGI(FGI), .FGO(FGO),
    .flags(flags), .irq_pending(irq_pending)
  );

  always #5 clk = ~clk;

  task automatic clear_ctrl();
    bus_select = 3'd0; alu_select = 3'd0;
    ld_AR = 0; ld_PC = 0; ld_DR = 0; ld_AC = 0; ld_IR = 0; ld_TR = 0;
    clr_AR = 0; clr_PC = 0; clr_AC = 0;
    inc_AR = 0; inc_PC = 0; inc_DR = 0; inc_AC = 0;
    clr_E = 0; comp_E = 0; set_IEN = 0; clr_IEN = 0; set_R = 0; clr_R = 0;
    clr_FGI = 0; ld_OUTR = 0; write_en = 0;
    in_valid = 0; in_data = 8'h00; out_ready = 0;
  endtask

  task automatic model_reset();
    m_ar = 0; m_pc = 0; m_dr = 0; m_ac = 0; m_ir = 0; m_tr = 0;
    m_inpr = 0; m_outr = 0; m_e = 0; m_ien = 0; m_r = 0; m_fgi = 0; m_fgo = 1; m_flags = 0;
  endtask

  // Next architectural state from the current controls, using plain integer arithmetic.
  task automatic model_step();
    longint a, d, s, sa, sd, res;
    logic [15:0] bus_m;
    logic co, ovf, e_new, e_wr;
    a = m_ac; d = m_dr;
    case (bus_select)
      3'd0: bus_m = 0;
      3'd1: bus_m = {4'h0, m_ar};
      3'd2: bus_m = {4'h0, m_pc};
      3'd3: bus_m = m_dr;
      3'd4: bus_m = m_ac;
      3'd5: bus_m = m_ir;
      3'd6: bus_m = m_tr;
      default: bus_m = m_mem.exists(int'(m_ar)) ? m_mem[int'(m_ar)] : 16'hxxxx;
    endcase
    co = 0; ovf = 0; e_new = m_e; e_wr = 0; res = a;
    case (alu_select)
      3'd0: res = longint'(m_ac & m_dr);
      3'd1: begin
        s = a + d; res = s % 65536; co = (s >= 65536);
        sa = (a >= 32768) ? a - 65536 : a;
        sd = (d >= 32768) ? d - 65536 : d;
        ovf = (sa + sd > 32767) || (sa + sd < -32768);
        e_new = co; e_wr = 1;
      end
      3'd2: res = d;
      3'd3: res = 65535 - a;
      3'd4: res = a - (a % 256) + longint'(m_inpr);
      3'd5: begin res = a / 2 + (m_e ? 32768 : 0); e_new = (a % 2) == 1; e_wr = 1; end
      3'd6: begin res = (a * 2) % 65536 + (m_e ? 1 : 0); e_new = a >= 32768; e_wr = 1; end
      default: res = a;
    endcase

    n_ar = clr_AR ? 12'd0 : ld_AR ? bus_m[11:0] : inc_AR ? 12'((int'(m_ar) + 1) % 4096) : m_ar;
    n_pc = clr_PC ? 12'd0 : ld_PC ? bus_m[11:0] : inc_PC ? 12'((int'(m_pc) + 1) % 4096) : m_pc;
    n_dr = ld_DR ? bus_m : inc_DR ? 16'((int'(m_dr) + 1) % 65536) : m_dr;
    n_ac = clr_AC ? 16'd0 : ld_AC ? 16'(res) : inc_AC ? 16'((int'(m_ac) + 1) % 65536) : m_ac;
    n_ir = ld_IR ? bus_m : m_ir;
    n_tr = ld_TR ? bus_m : m_tr;
    n_flags = ld_AC ? {co, ovf, res >= 32768, res == 0} : m_flags;
    n_e = clr_E ? 1'b0 : comp_E ? ~m_e : (ld_AC && e_wr) ? e_new : m_e;
    n_ien = set_IEN ? 1'b1 : clr_IEN ? 1'b0 : m_ien;
    n_r = set_R ? 1'b1 : clr_R ? 1'b0 : m_r;
    n_fgi = m_fgi; n_inpr = m_inpr;
    if (clr_FGI) n_fgi = 0;
    else if (in_valid && !m_fgi) begin n_fgi = 1; n_inpr = in_data; end
    n_fgo = m_fgo; n_outr = m_outr;
    if (ld_OUTR) begin n_outr = m_ac[7:0]; n_fgo = 0; end
    else if (!m_fgo && out_ready) n_fgo = 1;
    if (write_en) m_mem[int'(m_ar)] = bus_m;
  endtask

  // One clock with the currently driven controls; controls return to idle afterwards.
  task automatic step();
    model_step();
    @(posedge clk); #1;
    m_ar = n_ar; m_pc = n_pc; m_dr = n_dr; m_ac = n_ac; m_ir = n_ir; m_tr = n_tr;
    m_flags = n_flags; m_e = n_e; m_ien = n_ien; m_r = n_r;
    m_fgi = n_fgi; m_inpr = n_inpr; m_fgo = n_fgo; m_outr = n_outr;
    clear_ctrl();
  endtask

  // AC only reaches arbitrary values through INPR: high byte, rotate 8 times, low byte.
  task automatic load_ac(input logic [15:0] v);
    clr_AC = 1; clr_E = 1; clr_FGI = 1; step();
    in_valid = 1; in_data = v[15:8]; step();
    ld_AC = 1; alu_select = 3'd4; clr_FGI = 1; step();
    repeat (8) begin ld_AC = 1; alu_select = 3'd6; step(); end
    in_valid = 1; in_data = v[7:0]; step();
    ld_AC = 1; alu_select = 3'd4; clr_FGI = 1; step();
  endtask

  task automatic test_reset();
    clear_ctrl();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    total++; if ({AR, PC, DR, AC, IR, TR} !== '0) begin bad++; $display("FAIL reset_regs: got %h want 0", {AR, PC, DR, AC, IR, TR}); end
    total++; if ({E, IEN, R, FGI, FGO} !== 5'b00001) begin bad++; $display("FAIL reset_flagregs: got %b want 00001", {E, IEN, R, FGI, FGO}); end
    total++; if (flags !== 4'b0000) begin bad++; $display("FAIL reset_flags: got %b want 0000", flags); end
    total++; if ({in_ready, out_valid, out_data, irq_pending} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
      bad++; $display("FAIL reset_io: got %b want 1_0_00000000_0", {in_ready, out_valid, out_data, irq_pending}); end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_op();
    load_ac(16'h0050);
    bus_select = 3'd4; ld_PC = 1; ld_OUTR = 1; step();
    load_ac(16'h1234);
    total++; if ({AC, PC, FGO} !== {16'h1234, 12'h050, 1'b0}) begin
      bad++; $display("FAIL midrst_setup: got %h %h %b want 1234 050 0", AC, PC, FGO); end
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    total++; if ({AC, PC, FGO} !== {16'h0000, 12'h000, 1'b1}) begin
      bad++; $display("FAIL midrst_async: got %h %h %b want 0000 000 1", AC, PC, FGO); end
    #1 rst_n = 1'b1;
    ld_AC = 1; alu_select = 3'd7; step();
    total++; if (AC !== 16'h0000) begin bad++; $display("FAIL midrst_pass: got %h want 0000", AC); end
  endtask

  task automatic test_add();
    load_ac(16'h0001);
    bus_select = 3'd4; ld_DR = 1; step();
    load_ac(16'h7FFF);
    ld_AC = 1; alu_select = 3'd1; step();
    total++; if ({AC, E, flags} !== {16'h8000, 1'b0, 4'b0110}) begin
      bad++; $display("FAIL add_ovf: got %h %b %b want 8000 0 0110", AC, E, flags); end
    load_ac(16'hFFFF);
    ld_AC = 1; alu_select = 3'd1; step();
    total++; if ({AC, E, flags} !== {16'h0000, 1'b1, 4'b1001}) begin
      bad++; $display("FAIL add_carry: got %h %b %b want 0000 1 1001", AC, E, flags); end
    load_ac(16'h0001);
    comp_E = 1; step();
    total++; if (E !== 1'b1) begin bad++; $display("FAIL add_eset: got %b want 1", E); end
    ld_AC = 1; alu_select = 3'd1; step();
    total++; if ({AC, E, flags} !== {16'h0002, 1'b0, 4'b0000}) begin
      bad++; $display("FAIL add_eclr: got %h %b %b want 0002 0 0000", AC, E, flags); end
  endtask

  task automatic test_rotate();
    load_ac(16'h8001);
    comp_E = 1; step();
    ld_AC = 1; alu_select = 3'd6; step();
    total++; if ({AC, E} !== {16'h0003, 1'b1}) begin bad++; $display("FAIL cil: got %h %b want 0003 1", AC, E); end
    load_ac(16'h0001);
    ld_AC = 1; alu_select = 3'd5; step();
    total++; if ({AC, E, flags} !== {16'h0000, 1'b1, 4'b0001}) begin
      bad++; $display("FAIL cir: got %h %b %b want 0000 1 0001", AC, E, flags); end
    clr_E = 1; comp_E = 1; step();
    total++; if (E !== 1'b0) begin bad++; $display("FAIL e_prio: got %b want 0", E); end
  endtask

  task automatic test_input();
    load_ac(16'h1200);
    ld_OUTR = 1; step();
    in_valid = 1; in_data = 8'hA5; step();
    total++; if ({FGI, in_ready} !== 2'b10) begin bad++; $display("FAIL in_capture: got %b want 10", {FGI, in_ready}); end
    in_valid = 1; in_data = 8'h5A; step();
    ld_AC = 1; alu_select = 3'd4; step();
    total++; if (AC !== 16'h12A5) begin bad++; $display("FAIL in_inp: got %h want 12a5", AC); end
    set_IEN = 1; clr_IEN = 1; step();
    total++; if ({IEN, irq_pending} !== 2'b11) begin bad++; $display("FAIL in_irq: got %b want 11", {IEN, irq_pending}); end
    clr_FGI = 1; step();
    total++; if ({in_ready, irq_pending} !== 2'b10) begin bad++; $display("FAIL in_clr: got %b want 10", {in_ready, irq_pending}); end
    in_valid = 1; in_data = 8'h3C; clr_FGI = 1; step();
    total++; if (FGI !== 1'b0) begin bad++; $display("FAIL in_clr_wins: got %b want 0", FGI); end
    ld_AC = 1; alu_select = 3'd4; step();
    total++; if (AC !== 16'h12A5) begin bad++; $display("FAIL in_hold: got %h want 12a5", AC); end
    clr_IEN = 1; step();
  endtask

  task automatic test_output();
    load_ac(16'h1234);
    ld_OUTR = 1; step();
    total++; if ({out_data, out_valid} !== {8'h34, 1'b1}) begin
      bad++; $display("FAIL out_load: got %h %b want 34 1", out_data, out_valid); end
    for (int i = 0; i < 3; i++) begin
      out_ready = 0; step();
      total++; if ({out_data, out_valid} !== {8'h34, 1'b1}) begin
        bad++; $display("FAIL out_hold%0d: got %h %b want 34 1", i, out_data, out_valid); end
    end
    out_ready = 1; step();
    total++; if ({FGO, out_valid} !== 2'b10) begin bad++; $display("FAIL out_accept: got %b want 10", {FGO, out_valid}); end
    ld_OUTR = 1; step();
    inc_AC = 1; step();
    ld_OUTR = 1; out_ready = 1; step();
    total++; if ({out_data, FGO} !== {8'h35, 1'b0}) begin
      bad++; $display("FAIL out_reload_wins: got %h %b want 35 0", out_data, FGO); end
  endtask

  task automatic test_priority_mem();
    load_ac(16'h0FFF);
    bus_select = 3'd4; ld_PC = 1; step();
    inc_PC = 1; step();
    total++; if (PC !== 12'h000) begin bad++; $display("FAIL pc_wrap: got %h want 000", PC); end
    inc_PC = 1; step();
    bus_select = 3'd4; clr_PC = 1; ld_PC = 1; inc_PC = 1; step();
    total++; if (PC !== 12'h000) begin bad++; $display("FAIL pc_prio: got %h want 000", PC); end
    bus_select = 3'd4; ld_PC = 1; inc_PC = 1; step();
    total++; if (PC !== 12'hFFF) begin bad++; $display("FAIL pc_ld_over_inc: got %h want fff", PC); end
    bus_select = 3'd4; ld_AR = 1; step();
    inc_AR = 1; step();
    total++; if (AR !== 12'h000) begin bad++; $display("FAIL ar_wrap: got %h want 000", AR); end
    bus_select = 3'd4; ld_AR = 1; step();
    load_ac(16'hBEEF);
    bus_select = 3'd4; write_en = 1; step();
    bus_select = 3'd7; ld_DR = 1; step();
    total++; if (DR !== 16'hBEEF) begin bad++; $display("FAIL mem_rd: got %h want beef", DR); end
    load_ac(16'hFFFF);
    inc_AC = 1; step();
    total++; if ({AC, E, flags} !== {16'h0000, 1'b0, 4'b0010}) begin
      bad++; $display("FAIL ac_wrap: got %h %b %b want 0000 0 0010", AC, E, flags); end
    bus_select = 3'd1; ld_TR = 1; step();
    total++; if (TR !== 16'h0FFF) begin bad++; $display("FAIL bus_ar_zext: got %h want 0fff", TR); end
  endtask

  task automatic test_random();
    logic [107:0] got, exp;
    for (int it = 0; it < 400; it++) begin
      bus_select = 3'($urandom_range(0, 7));
      if (bus_select == 3'd7 && !m_mem.exists(int'(m_ar))) bus_select = 3'd4;
      alu_select = 3'($urandom_range(0, 7));
      ld_AR = ($urandom_range(0, 5) == 0); ld_PC = ($urandom_range(0, 5) == 0);
      ld_DR = ($urandom_range(0, 3) == 0); ld_AC = ($urandom_range(0, 1) == 0);
      ld_IR = ($urandom_range(0, 5) == 0); ld_TR = ($urandom_range(0, 5) == 0);
      clr_AR = ($urandom_range(0, 9) == 0); clr_PC = ($urandom_range(0, 9) == 0);
      clr_AC = ($urandom_range(0, 9) == 0);
      inc_AR = ($urandom_range(0, 3) == 0); inc_PC = ($urandom_range(0, 3) == 0);
      inc_DR = ($urandom_range(0, 3) == 0); inc_AC = ($urandom_range(0, 3) == 0);
      clr_E = ($urandom_range(0, 7) == 0); comp_E = ($urandom_range(0, 5) == 0);
      set_IEN = ($urandom_range(0, 5) == 0); clr_IEN = ($urandom_range(0, 5) == 0);
      set_R = ($urandom_range(0, 5) == 0); clr_R = ($urandom_range(0, 5) == 0);
      clr_FGI = ($urandom_range(0, 3) == 0); ld_OUTR = ($urandom_range(0, 3) == 0);
      write_en = ($urandom_range(0, 3) == 0);
      in_valid = ($urandom_range(0, 1) == 0); in_data = 8'($urandom);
      out_ready = ($urandom_range(0, 1) == 0);
      step();
      got = {AR, PC, DR, AC, IR, TR, E, IEN, R, FGI, FGO, flags, out_data, in_ready, out_valid, irq_pending};
      exp = {m_ar, m_pc, m_dr, m_ac, m_ir, m_tr, m_e, m_ien, m_r, m_fgi, m_fgo, m_flags, m_outr,
             ~m_fgi, ~m_fgo, m_ien & (m_fgi | m_fgo)};
      total++;
      if (got !== exp) begin
        bad++; $display("FAIL rand%0d: got %h want %h", it, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_op();
    test_add();
    test_rotate();
    test_input();
    test_output();
    test_priority_mem();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
